// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared parameters and helpers for the register pipe
package reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// rtl/reg_pipe_if.sv - handshake bundle between a register pipe and its neighbours
interface reg_pipe_if
  import reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  logic                    flush;
  logic                    in_valid;
  logic [WIDTH-1:0]        in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ready;
  logic [cnt_w(DEPTH)-1:0] count;

  // Environment side: produces input words, consumes output words.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  // Pipe side.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/reg_stage.sv
// rtl/reg_stage.sv - one pipe stage: enabled data register plus valid bit
module reg_stage
  import reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Bubbles move the valid bit only; data is captured just for real words.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - bubble-collapsing register pipeline with occupancy count
module reg_pipe
  import reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic       clk,
  input logic       rst,
  reg_pipe_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    cnt;
  logic             in_xfer;
  logic             out_xfer;

  // A stage may move when the one after it moves or when it holds a bubble.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = bus.out_ready | ~v[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = adv[i+1] | ~v[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    if (i == 0) begin : g_head
      assign pv = bus.in_valid;
      assign pd = bus.in_data;
    end else begin : g_body
      assign pv = v[i-1];
      assign pd = d[i-1];
    end
    reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv[i]),
      .flush      (bus.flush),
      .prev_valid (pv),
      .prev_data  (pd),
      .valid      (v[i]),
      .data       (d[i])
    );
  end

  assign bus.in_ready  = adv[0] & ~bus.flush & rst;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.count     = cnt;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = v[DEPTH-1] & bus.out_ready;

  // Occupancy tracks accepted minus emitted words; flush empties it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-005 SHALL have port flush  input  1  synchronous clear of all stage valid bits.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_data  input  WIDTH  upstream data word.
REQ-008 SHALL have port in_ready  output  1  pipe accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  last stage holds valid data.
REQ-010 SHALL have port out_data  output  WIDTH  last-stage data word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-013 SHALL hold DEPTH stages s[0..DEPTH-1], each a WIDTH-bit data register plus a valid bit; s[0] is input side, s[DEPTH-1] drives out_data/out_valid directly (registered, no combinational path from in_data).
REQ-014 SHALL compute per-stage advance: adv[DEPTH-1] = out_ready OR NOT v[DEPTH-1]; adv[i] = adv[i+1] OR NOT v[i] (bubble-collapsing).
REQ-015 SHALL drive in_ready = adv[0] AND flush low AND rst high.
REQ-016 SHALL transfer input when in_valid AND in_ready; output transfer when out_valid AND out_ready.
REQ-017 SHALL, on rising edge with adv[i] high, load s[i] from s[i-1] (s[0] from in_data/in_valid); stage with adv low holds data and valid unchanged.
REQ-018 SHALL load data registers only when the incoming valid is 1; a stage receiving a bubble clears its valid bit but keeps stale data.
REQ-019 SHALL give latency DEPTH cycles from accepted input to out_valid when out_ready held high; throughput one word per cycle.
REQ-020 SHALL never drop or duplicate a word; order preserved FIFO-style.
REQ-021 SHALL, when full (count = DEPTH) and out_ready low, drive in_ready low; with out_ready high and full, in_ready stays high (simultaneous accept and emit, count unchanged).
REQ-022 SHALL, when empty, keep out_valid low and out_data at last held value.
REQ-023 SHALL update count next cycle as count + in_xfer - out_xfer; never exceeds DEPTH or underflows.
REQ-024 SHALL, on flush high at a rising edge, clear all valid bits and count to 0, ignoring in_valid and out_ready that cycle; data registers unchanged.
REQ-025 SHALL, for DEPTH = 1, behave as single enabled register with valid: load when empty or out_ready.

Reset
REQ-026 SHALL, when rst low at a rising edge, set all valid bits 0, all data registers 0, count 0; out_valid 0, out_data 0 the following cycle.
REQ-027 SHALL give rst priority over flush and any transfer; reset mid-stream discards all in-flight words.
REQ-028 SHALL hold in_ready low while rst is low.

Structure
REQ-029 SHALL place WIDTH/DEPTH defaults and count-width function in shared package reg_pkg.
REQ-030 SHALL implement each stage as sub-module reg_stage (WIDTH-bit enabled register plus valid bit, synchronous active-low reset, adv as enable), instantiated DEPTH times via generate.
REQ-031 SHALL contain no latches and no asynchronous logic.

Verification
REQ-032 SHALL cover: WIDTH=8, DEPTH=4, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 at cycles 4,5,6, count peaks 3.
REQ-033 SHALL cover: out_ready=0, push 5 words 0xA0..0xA4 -> first 4 accepted, in_ready low on fifth, count=4; release out_ready -> 0xA0..0xA3 emerge, then 0xA4 accepted.
REQ-034 SHALL cover: full pipe, in_valid=1 and out_ready=1 same cycle -> one word in, one out, count stays 4.
REQ-035 SHALL cover: 3 words in flight, flush pulse 1 cycle -> count 0, out_valid 0 next cycle, no flushed word ever emerges.
REQ-036 SHALL cover: rst low for 1 cycle with 2 words in flight -> out_valid 0, out_data 0x00, count 0; new word 0x5A after reset emerges after 4 cycles.
REQ-037 SHALL cover: DEPTH=1, random in_valid/out_ready for 1000 cycles -> scoreboard matches order, no loss/duplication.
